// File: rtl/ascon_round_ctrl_dom.sv
// ---------------------------------------------------------------------------
// ascon_round_ctrl_dom
//
// Round sequencer for a DOM-protected ASCON permutation datapath. A single
// start pulse runs p^a (12 rounds from index 0), p^b for ASCON-128 (6 rounds
// from index 6), p^b for ASCON-128a (8 rounds from index 4), or a custom run
// from start_idx. Each step issues UNROLL round constants. Consecutive steps
// are spaced ROUND_LAT cycles apart so they line up with the register
// latency of the masked gadgets.
//
// Parameters
//   UNROLL     rounds per step (1..4); one constant lane per round
//   ROUND_LAT  cycles per step (>=1)
//
// Ports
//   clk         rising-edge clock
//   nRST        asynchronous reset, active low
//   start       start pulse; honoured only in IDLE or in the DONE cycle
//   abort       synchronous abort; returns to IDLE, beats start and all moves
//   mode        00 p^a, 01 p^b(6), 10 p^b(8), 11 custom start_idx
//   start_idx   first round index for mode 11 (0..11 accepted)
//   busy        high from the first step cycle through the done cycle
//   round_en    step strobe; the datapath consumes the lanes this cycle
//   lane_valid  bit k set when lane k carries a real round in this step
//   constt      lane k = constt[8k+7:8k] = {~idx_k, idx_k}, idx_k = idx+k
//   last        high with round_en on the final step
//   done        one-cycle pulse ROUND_LAT cycles after the last round_en
//   err         one-cycle pulse after a rejected custom start
// ---------------------------------------------------------------------------
module ascon_round_ctrl_dom #(
    parameter int UNROLL    = 1,
    parameter int ROUND_LAT = 1
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [3:0]            start_idx,
    output logic                  busy,
    output logic                  round_en,
    output logic [UNROLL-1:0]     lane_valid,
    output logic [8*UNROLL-1:0]   constt,
    output logic                  last,
    output logic                  done,
    output logic                  err
);

    // Wait counter holds at most ROUND_LAT-1.
    localparam int         CNT_W   = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [4:0] IDX_MAX = 5'd11;
    localparam logic [4:0] STEP    = 5'(UNROLL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_pend_reg, last_pend_next;
    logic             err_reg, err_next;

    logic [3:0]       load_idx;
    logic             start_ok;
    logic [4:0]       idx_sum;
    logic             step_last;

    // First round index selected by mode; only latched on an accepted start.
    always_comb begin
        load_idx = start_idx;
        case (mode)
            2'b00:   load_idx = 4'd0;
            2'b01:   load_idx = 4'd6;
            2'b10:   load_idx = 4'd4;
            default: load_idx = start_idx;
        endcase
    end

    assign start_ok = (mode != 2'b11) || ({1'b0, start_idx} <= IDX_MAX);

    // 5-bit sum so idx+UNROLL past 15 cannot wrap back into the valid range.
    assign idx_sum   = {1'b0, idx_reg} + STEP;
    assign step_last = (idx_sum > IDX_MAX);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        last_pend_next = last_pend_reg;
        err_next       = 1'b0;

        if (abort) begin
            state_next     = S_IDLE;
            idx_next       = '0;
            cnt_next       = '0;
            last_pend_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (start_ok) begin
                            state_next     = S_RUN;
                            idx_next       = load_idx;
                            last_pend_next = 1'b0;
                        end else begin
                            state_next = S_IDLE;
                            err_next   = 1'b1;
                        end
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_RUN: begin
                    // Upper index bits past the final step are never consumed.
                    idx_next = idx_sum[3:0];
                    if (ROUND_LAT == 1) begin
                        state_next = step_last ? S_DONE : S_RUN;
                    end else begin
                        state_next     = S_WAIT;
                        cnt_next       = CNT_W'(ROUND_LAT - 1);
                        last_pend_next = step_last;
                    end
                end
                S_WAIT: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = last_pend_reg ? S_DONE : S_RUN;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            last_pend_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            last_pend_reg <= last_pend_next;
            err_reg       <= err_next;
        end
    end

    // Outputs decode straight from registers so reset clears them at once.
    assign round_en = (state_reg == S_RUN);
    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign last     = round_en && step_last;
    assign err      = err_reg;

    // Lanes are gated by round_en so the constant nets stay at zero between
    // steps; lanes beyond round 11 are zero as well.
    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_lane
            logic [4:0] lane_idx;
            assign lane_idx           = {1'b0, idx_reg} + 5'(gi);
            assign lane_valid[gi]     = round_en && (lane_idx <= IDX_MAX);
            assign constt[8*gi +: 8]  = lane_valid[gi] ? {~lane_idx[3:0], lane_idx[3:0]} : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_ascon_round_ctrl_dom.sv
// ---------------------------------------------------------------------------
// tb_ascon_round_ctrl_dom
//
// Three controllers (U=1/L=1, U=4/L=1, U=1/L=3) share one stimulus stream.
// A schedule model tracks, per configuration, whether a permutation is in
// flight and how many cycles have elapsed since its start; expected outputs
// come from that cycle offset by plain arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ascon_round_ctrl_dom;

    localparam int UC [3] = '{1, 4, 1};
    localparam int LC [3] = '{1, 1, 3};

    logic clk = 1'b0;
    logic nRST, start, abort;
    logic [1:0] mode;
    logic [3:0] start_idx;

    logic busy_a, re_a, last_a, done_a, err_a;
    logic [0:0]  lv_a;
    logic [7:0]  ct_a;
    logic busy_b, re_b, last_b, done_b, err_b;
    logic [3:0]  lv_b;
    logic [31:0] ct_b;
    logic busy_c, re_c, last_c, done_c, err_c;
    logic [0:0]  lv_c;
    logic [7:0]  ct_c;

    logic [40:0] obs [3];

    int n_checks = 0;
    int n_pass   = 0;

    // Schedule model state
    bit m_active [3];
    bit m_err    [3];
    int m_t      [3];
    int m_idx0   [3];
    int m_steps  [3];

    logic [7:0] t1_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    always #5 clk = ~clk;

    ascon_round_ctrl_dom #(.UNROLL(1), .ROUND_LAT(1)) dut_a (
        .clk(clk), .nRST(nRST), .start(start), .abort(abort), .mode(mode),
        .start_idx(start_idx), .busy(busy_a), .round_en(re_a), .lane_valid(lv_a),
        .constt(ct_a), .last(last_a), .done(done_a), .err(err_a));

    ascon_round_ctrl_dom #(.UNROLL(4), .ROUND_LAT(1)) dut_b (
        .clk(clk), .nRST(nRST), .start(start), .abort(abort), .mode(mode),
        .start_idx(start_idx), .busy(busy_b), .round_en(re_b), .lane_valid(lv_b),
        .constt(ct_b), .last(last_b), .done(done_b), .err(err_b));

    ascon_round_ctrl_dom #(.UNROLL(1), .ROUND_LAT(3)) dut_c (
        .clk(clk), .nRST(nRST), .start(start), .abort(abort), .mode(mode),
        .start_idx(start_idx), .busy(busy_c), .round_en(re_c), .lane_valid(lv_c),
        .constt(ct_c), .last(last_c), .done(done_c), .err(err_c));

    assign obs[0] = {busy_a, re_a, last_a, done_a, err_a, 3'b000, lv_a, 24'h0, ct_a};
    assign obs[1] = {busy_b, re_b, last_b, done_b, err_b, lv_b, ct_b};
    assign obs[2] = {busy_c, re_c, last_c, done_c, err_c, 3'b000, lv_c, 24'h0, ct_c};

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_active[c] = 1'b0;
            m_err[c]    = 1'b0;
            m_t[c]      = 0;
        end
    endfunction

    // Advance the schedule by one clock edge using the inputs held this cycle.
    function automatic void model_step();
        bit in_done;
        bit can_start;
        int sel;
        for (int c = 0; c < 3; c++) begin
            in_done   = m_active[c] && (m_t[c] == 1 + m_steps[c] * LC[c]);
            can_start = !m_active[c] || in_done;
            m_err[c]  = 1'b0;
            if (abort) begin
                m_active[c] = 1'b0;
            end else begin
                if (m_active[c]) begin
                    if (in_done) m_active[c] = 1'b0;
                    else         m_t[c]      = m_t[c] + 1;
                end
                if (start && can_start) begin
                    case (mode)
                        2'b00:   sel = 0;
                        2'b01:   sel = 6;
                        2'b10:   sel = 4;
                        default: sel = int'(start_idx);
                    endcase
                    if (sel > 11) begin
                        m_err[c] = 1'b1;
                    end else begin
                        m_active[c] = 1'b1;
                        m_t[c]      = 1;
                        m_idx0[c]   = sel;
                        m_steps[c]  = (12 - sel + UC[c] - 1) / UC[c];
                    end
                end
            end
        end
    endfunction

    function automatic logic [40:0] expect_out(int c);
        logic b, re, la, dn;
        logic [3:0]  lv;
        logic [31:0] ct;
        int j, i;
        b = m_active[c]; re = 1'b0; la = 1'b0; dn = 1'b0; lv = '0; ct = '0;
        if (m_active[c]) begin
            if (((m_t[c] - 1) % LC[c] == 0) && ((m_t[c] - 1) / LC[c] < m_steps[c])) begin
                re = 1'b1;
                j  = (m_t[c] - 1) / LC[c];
                la = (j == m_steps[c] - 1);
                for (int k = 0; k < UC[c]; k++) begin
                    i = m_idx0[c] + j * UC[c] + k;
                    if (i <= 11) begin
                        lv[k]        = 1'b1;
                        ct[8*k +: 8] = 8'((15 - i) * 16 + i);
                    end
                end
            end
            dn = (m_t[c] == 1 + m_steps[c] * LC[c]);
        end
        return {b, re, la, dn, m_err[c], lv, ct};
    endfunction

    // Entered and left at a falling edge: inputs change, then one clock edge.
    task automatic drive_cycle(input logic s, input logic a, input logic [1:0] m,
                               input logic [3:0] si);
        start = s; abort = a; mode = m; start_idx = si;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [40:0] exp_v;
        nRST = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; start_idx = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs[c] !== 41'h0)
                $display("FAIL reset_outputs cfg%0d got=%h want=%h", c, obs[c], 41'h0);
            else n_pass++;
        end
        nRST = 1'b1;
        // abort together with start in IDLE: abort wins, nothing happens
        drive_cycle(1'b1, 1'b1, 2'b11, 4'd13);
        for (int c = 0; c < 3; c++) begin
            exp_v = expect_out(c);
            n_checks++;
            if (obs[c] !== exp_v)
                $display("FAIL idle_abort cfg%0d got=%h want=%h", c, obs[c], exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_fixed_runs();
        logic [1:0] fm [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        logic [3:0] fi [5] = '{4'd0, 4'd0, 4'd0, 4'd11, 4'd13};
        logic [40:0] exp_v;
        for (int r = 0; r < 5; r++) begin
            drive_cycle(1'b1, 1'b0, fm[r], fi[r]);
            for (int n = 1; n <= 40; n++) begin
                for (int c = 0; c < 3; c++) begin
                    exp_v = expect_out(c);
                    n_checks++;
                    if (obs[c] !== exp_v)
                        $display("FAIL fixed_run%0d cfg%0d cyc%0d got=%h want=%h", r, c, n, obs[c], exp_v);
                    else n_pass++;
                end
                if (r == 0 && n <= 12) begin
                    n_checks++;
                    if (ct_a !== t1_tab[n-1])
                        $display("FAIL pa_constt cyc%0d got=%h want=%h", n, ct_a, t1_tab[n-1]);
                    else n_pass++;
                end
                if (r == 0 && n == 13) begin
                    n_checks++;
                    if (done_a !== 1'b1) $display("FAIL pa_done cyc13 got=%b want=1", done_a);
                    else n_pass++;
                end
                if (r == 4 && n == 1) begin
                    n_checks++;
                    if ({err_a, busy_a} !== 2'b10)
                        $display("FAIL bad_idx_err got err=%b busy=%b want err=1 busy=0", err_a, busy_a);
                    else n_pass++;
                end
                // mode/start_idx wander while start is low; a run must not notice
                drive_cycle(1'b0, 1'b0, 2'($urandom), 4'($urandom));
            end
        end
    endtask

    task automatic test_abort();
        logic [40:0] exp_v;
        drive_cycle(1'b1, 1'b0, 2'b00, 4'd0);
        for (int n = 1; n <= 50; n++) begin
            for (int c = 0; c < 3; c++) begin
                exp_v = expect_out(c);
                n_checks++;
                if (obs[c] !== exp_v)
                    $display("FAIL abort cfg%0d cyc%0d got=%h want=%h", c, n, obs[c], exp_v);
                else n_pass++;
            end
            if (n == 6) begin
                n_checks++;
                if (obs[0] !== 41'h0) $display("FAIL abort_quiet got=%h want=0", obs[0]);
                else n_pass++;
            end
            if (n == 9) begin
                n_checks++;
                if (ct_a !== 8'hF0) $display("FAIL abort_restart got=%h want=f0", ct_a);
                else n_pass++;
            end
            if (n == 5)      drive_cycle(1'b0, 1'b1, 2'b00, 4'd0);
            else if (n == 6) drive_cycle(1'b1, 1'b1, 2'b11, 4'd14);
            else if (n == 8) drive_cycle(1'b1, 1'b0, 2'b00, 4'd0);
            else             drive_cycle(1'b0, 1'b0, 2'b00, 4'd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [40:0] exp_v;
        drive_cycle(1'b1, 1'b0, 2'b01, 4'd0);
        for (int n = 1; n <= 40; n++) begin
            for (int c = 0; c < 3; c++) begin
                exp_v = expect_out(c);
                n_checks++;
                if (obs[c] !== exp_v)
                    $display("FAIL back_to_back cfg%0d cyc%0d got=%h want=%h", c, n, obs[c], exp_v);
                else n_pass++;
            end
            if (n == 8) begin
                n_checks++;
                if ({re_a, ct_a} !== {1'b1, 8'hB4})
                    $display("FAIL b2b_no_gap got re=%b ct=%h want re=1 ct=b4", re_a, ct_a);
                else n_pass++;
            end
            // cycle 7 is the DONE cycle of the U=1/L=1 run; U=1/L=3 is mid-run
            if (n == 7) drive_cycle(1'b1, 1'b0, 2'b10, 4'd0);
            else        drive_cycle(1'b0, 1'b0, 2'($urandom), 4'($urandom));
        end
    endtask

    task automatic test_nrst_async();
        logic [40:0] exp_v;
        drive_cycle(1'b1, 1'b0, 2'b00, 4'd0);
        repeat (3) drive_cycle(1'b0, 1'b0, 2'b00, 4'd0);
        #2 nRST = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (obs[c] !== 41'h0)
                $display("FAIL async_reset cfg%0d got=%h want=0", c, obs[c]);
            else n_pass++;
        end
        model_reset();
        @(negedge clk);
        nRST = 1'b1;
        drive_cycle(1'b0, 1'b0, 2'b00, 4'd0);
        for (int c = 0; c < 3; c++) begin
            exp_v = expect_out(c);
            n_checks++;
            if (obs[c] !== exp_v)
                $display("FAIL after_reset cfg%0d got=%h want=%h", c, obs[c], exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [40:0] exp_v;
        logic s, a;
        for (int n = 0; n < 600; n++) begin
            s = ($urandom_range(0, 4) == 0);
            a = ($urandom_range(0, 24) == 0);
            drive_cycle(s, a, 2'($urandom), 4'($urandom_range(0, 15)));
            for (int c = 0; c < 3; c++) begin
                exp_v = expect_out(c);
                n_checks++;
                if (obs[c] !== exp_v)
                    $display("FAIL random cfg%0d cyc%0d got=%h want=%h", c, n, obs[c], exp_v);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_runs();
        test_abort();
        test_back_to_back();
        test_nrst_async();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
